// File: rtl/dct_pkg.sv
// Shared constants and element-packing helper for the 8x8 DCT transpose path.
// Element k of a packed DATA_WIDTH*8 vector lives at [k*DATA_WIDTH +: DATA_WIDTH].
package dct_pkg;

   localparam int DCT_N     = 8;
   localparam int DCT_IDX_W = 3;

   typedef logic [DCT_IDX_W-1:0] dct_idx_t;

   function automatic int unsigned dct_elem_lsb(input int unsigned k, input int unsigned width);
      return k * width;
   endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 word register bank: row-wide write port, combinational column-wide read port.
// Storage clears on reset so an empty bank presents all-zero columns.
module dct_tbuf_bank
   import dct_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        we,
   input  logic [DCT_IDX_W-1:0]        wr_row,
   input  logic [DATA_WIDTH*DCT_N-1:0] wr_data,
   input  logic [DCT_IDX_W-1:0]        rd_col,
   output logic [DATA_WIDTH*DCT_N-1:0] rd_data
);

   // mem_reg[row][col]
   logic [DATA_WIDTH-1:0] mem_reg [DCT_N][DCT_N];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < DCT_N; r++) begin
            for (int c = 0; c < DCT_N; c++) begin
               mem_reg[r][c] <= '0;
            end
         end
      end else if (we) begin
         for (int c = 0; c < DCT_N; c++) begin
            mem_reg[wr_row][c] <= wr_data[dct_elem_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DCT_N; gi++) begin : g_rd
         assign rd_data[dct_elem_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = mem_reg[gi][rd_col];
      end
   endgenerate

endmodule

// File: rtl/dct_transpose_8x8.sv
// Row-in / column-out transpose buffer between the DCT row and column passes.
// Define DCT_TRANSPOSE_PINGPONG_EN for two banks; otherwise a single bank is used.
module dct_transpose_8x8
   import dct_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_WIDTH*DCT_N-1:0] row_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH*DCT_N-1:0] col_out,
   output logic [DCT_IDX_W-1:0]        out_col_idx,
   output logic                        out_last
);

   localparam dct_idx_t LAST_IDX = DCT_IDX_W'(DCT_N - 1);

   dct_idx_t wr_row_reg, wr_row_next;
   dct_idx_t rd_col_reg, rd_col_next;
   logic     wr_fire, rd_fire, wr_done, rd_done;

   assign wr_fire = in_valid && in_ready;
   assign rd_fire = out_valid && out_ready;
   assign wr_done = wr_fire && (wr_row_reg == LAST_IDX);
   assign rd_done = rd_fire && (rd_col_reg == LAST_IDX);

   always_comb begin
      wr_row_next = wr_row_reg;
      rd_col_next = rd_col_reg;
      if (wr_fire) begin
         wr_row_next = wr_done ? '0 : wr_row_reg + 1'b1;
      end
      if (rd_fire) begin
         rd_col_next = rd_done ? '0 : rd_col_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_row_reg <= '0;
         rd_col_reg <= '0;
      end else begin
         wr_row_reg <= wr_row_next;
         rd_col_reg <= rd_col_next;
      end
   end

   assign out_col_idx = rd_col_reg;
   assign out_last    = out_valid && (rd_col_reg == LAST_IDX);

   genvar gi;

`ifdef DCT_TRANSPOSE_PINGPONG_EN
   logic [1:0]                  full_reg, full_next;
   logic                        wr_bank_reg, wr_bank_next;
   logic                        rd_bank_reg, rd_bank_next;
   logic [DATA_WIDTH*DCT_N-1:0] bank_col [2];

   // Set and clear never hit the same bank: a full bank is never written.
   always_comb begin
      full_next    = full_reg;
      wr_bank_next = wr_bank_reg;
      rd_bank_next = rd_bank_reg;
      if (wr_done) begin
         full_next[wr_bank_reg] = 1'b1;
         wr_bank_next           = ~wr_bank_reg;
      end
      if (rd_done) begin
         full_next[rd_bank_reg] = 1'b0;
         rd_bank_next           = ~rd_bank_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_reg    <= '0;
         wr_bank_reg <= 1'b0;
         rd_bank_reg <= 1'b0;
      end else begin
         full_reg    <= full_next;
         wr_bank_reg <= wr_bank_next;
         rd_bank_reg <= rd_bank_next;
      end
   end

   assign in_ready  = ~full_reg[wr_bank_reg];
   assign out_valid = full_reg[rd_bank_reg];

   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         dct_tbuf_bank #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (wr_fire && (wr_bank_reg == 1'(gi))),
            .wr_row  (wr_row_reg),
            .wr_data (row_in),
            .rd_col  (rd_col_reg),
            .rd_data (bank_col[gi])
         );
      end
   endgenerate

   assign col_out = bank_col[rd_bank_reg];
`else
   logic                        full_reg, full_next;
   logic [DATA_WIDTH*DCT_N-1:0] bank_col [1];

   always_comb begin
      full_next = full_reg;
      if (wr_done) begin
         full_next = 1'b1;
      end
      if (rd_done) begin
         full_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_reg <= 1'b0;
      end else begin
         full_reg <= full_next;
      end
   end

   assign in_ready  = ~full_reg;
   assign out_valid = full_reg;

   generate
      for (gi = 0; gi < 1; gi++) begin : g_bank
         dct_tbuf_bank #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (wr_fire),
            .wr_row  (wr_row_reg),
            .wr_data (row_in),
            .rd_col  (rd_col_reg),
            .rd_data (bank_col[gi])
         );
      end
   endgenerate

   assign col_out = bank_col[0];
`endif

endmodule

// File: doc/dct_transpose_8x8.md
# dct_transpose_8x8

Row-to-column transpose buffer between the row pass and the column pass of the 8x8 2D DCT. It accepts one 8-element row per handshake, as produced by the 1D 8-point DCT row stage. It emits the same 8x8 block column by column, so the next 1D 8-point DCT stage can run the column pass. Element values are opaque DATA_WIDTH-bit words: the block only moves and reorders them, with no arithmetic. Storage is double-buffered (ping-pong), so the next block fills while the current one drains.

## Interface
- DATA_WIDTH, 32, width of one element word
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  row_in holds a valid row
- in_ready  output  1  block can accept a row this cycle
- row_in  input  DATA_WIDTH*8  one row; element c at [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  1  col_out holds a valid column
- out_ready  input  1  consumer accepts the column this cycle
- col_out  output  DATA_WIDTH*8  one column; element r (row index) at [r*DATA_WIDTH +: DATA_WIDTH]
- out_col_idx  output  3  index of the column currently presented
- out_last  output  1  high with out_valid when out_col_idx == 7

## Operation
- Two banks, B0 and B1. Each bank is 8x8 words plus a full flag.
- Write side:
  - State: wr_bank (1 bit) and wr_row (0..7).
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: store row_in into row wr_row of wr_bank.
  - If wr_row == 7: set full[wr_bank], toggle wr_bank, set wr_row to 0. Otherwise increment wr_row.
- Read side:
  - State: rd_bank (1 bit) and rd_col (0..7).
  - out_valid = full[rd_bank].
  - col_out[r] = bank[rd_bank][r][rd_col] for r = 0..7.
  - out_col_idx = rd_col.
  - On out_valid && out_ready: if rd_col == 7, clear full[rd_bank], toggle rd_bank, set rd_col to 0. Otherwise increment rd_col.
- Simultaneous events:
  - A set and a clear on full[] in the same cycle always target different banks, because a write into a full bank is impossible. Both take effect.
  - Blocks are emitted strictly in arrival order.
- Backpressure:
  - in_valid without in_ready: the row is not taken, and the row counter holds.
  - out_valid without out_ready: col_out, out_col_idx and out_last hold stable.
- The handshake contract is standard valid/ready. out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.
- Partial block (fewer than 8 rows) is held indefinitely. No timeout, no flush.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all bank words 0, full = 2'b00, wr_bank = rd_bank = 0, wr_row = rd_col = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, col_out = 0, out_col_idx = 0, out_last = 0.
- Reset mid-block discards all stored rows and all pending columns.
- Latency: the 8th row is accepted at edge N. out_valid = 1 in the cycle following edge N, with column 0 presented.
- Throughput: 1 row/cycle in, 1 column/cycle out. Sustained streaming gives zero bubbles on both sides.
- Both banks full: in_ready = 0 until column 7 of rd_bank is accepted. in_ready rises in the cycle after that acceptance.

## Configuration
- DCT_TRANSPOSE_PINGPONG_EN defined:
  - two banks, behaviour as above.
- DCT_TRANSPOSE_PINGPONG_EN undefined:
  - single bank (B0 only); wr_bank and rd_bank are tied to 0.
  - in_ready = 0 from acceptance of row 7 until acceptance of column 7.
  - Throughput drops to 1 block per 16 cycles plus consumer stalls.
  - Latency and the port list are unchanged.

## Structure
- Shared package dct_pkg holds:
  - DCT_N = 8
  - DCT_IDX_W = 3
  - the element-packing helper function: element k of a DATA_WIDTH*8 vector at [k*DATA_WIDTH +: DATA_WIDTH].
- Sub-module dct_tbuf_bank: one 8x8 register bank. It has a row write port (we, row index, row data) and a combinational column read port (column index, column data). It is instantiated twice, or once when ping-pong is disabled.
- The top level holds the counters, the full flags and the output multiplexing.

## Test plan
- Word encoding for all scenarios: word for row r, element c = 32'h0000_0rc0 (r and c as hex digits).
- Single block, out_ready = 1:
  - Stimulus: drive rows 0..7 back-to-back.
  - Required response: out_valid rises the cycle after row 7; column c carries element r = 32'h0000_0rc0 for r = 0..7.
  - out_last is high only on column 7.
- Streaming, 4 blocks with out_ready = 1:
  - in_ready stays 1 throughout (ping-pong build).
  - 32 columns come out in order with no gaps after the first.
- Backpressure:
  - Stimulus: out_ready = 0 while 16 rows are offered.
  - Required response: in_ready drops to 0 after row 15; rows 16+ are not taken.
  - Releasing out_ready for 8 cycles restores in_ready the next cycle.
- Output stall mid-block:
  - Stimulus: drop out_ready at column 3 for 5 cycles.
  - Required response: col_out and out_col_idx = 3 hold stable; the sequence resumes with 3 then 4.
- Reset mid-operation:
  - Stimulus: assert reset after 5 rows of block 1 while block 0 is draining at column 2.
  - Required response: out_valid = 0 and in_ready = 1 immediately; the next 8 rows form a fresh block starting at column 0.
- Macro undefined:
  - Stimulus: stream 2 blocks.
  - Required response: in_ready = 0 for exactly the 8 drain cycles of each block.
